// File: rtl/player_motion.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : player_motion                                                |
// | Desc    : Overworld tile-walk controller with collision and encounters. |
// |           Define PLAYER_NOCLIP_EN to drop boulder collision checks.     |
// | Rev     : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module player_motion #(
  parameter int START_X    = 300,
  parameter int START_Y    = 200,
  parameter int TILE       = 20,
  parameter int STEP       = 2,
  parameter int PLAYER_W   = 14,
  parameter int PLAYER_H   = 20,
  parameter int ENC_THRESH = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       battle_done,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic [1:0] facing,
  output logic       anim_frame,
  output logic       encounter,
  output logic       in_battle
);

  localparam logic [9:0]         c_START_X = 10'(START_X);
  localparam logic [9:0]         c_START_Y = 10'(START_Y);
  localparam logic [9:0]         c_STEP    = 10'(STEP);
  localparam logic signed [11:0] c_TILE    = 12'(TILE);
  localparam logic signed [11:0] c_PW      = 12'(PLAYER_W);
  localparam logic signed [11:0] c_PH      = 12'(PLAYER_H);
  localparam logic [4:0]         c_ENC     = 5'(ENC_THRESH);
  localparam logic [15:0]        c_SEED    = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_ENC  = 2'd2
  } t_state;

  t_state      r_state, w_state_nxt;
  logic [9:0]  r_x, r_y, r_tx, r_ty;
  logic [9:0]  w_x_nxt, w_y_nxt, w_tx_nxt, w_ty_nxt, w_sx, w_sy;
  logic [1:0]  r_facing, w_facing_nxt, r_acnt, w_acnt_nxt, w_dir;
  logic        r_anim, w_anim_nxt, r_enc, w_enc_nxt;
  logic        r_fs1, r_fs2, r_fs3, r_tick;
  logic [15:0] r_lfsr;
  logic        w_key_valid, w_oob, w_hit, w_blocked, w_grass;
  logic signed [11:0] w_tx, w_ty;

  function automatic logic f_hit(input logic signed [11:0] bx, input logic signed [11:0] by,
                                 input int x0, input int x1, input int y0, input int y1);
    int l;
    int t;
    l = int'(bx);
    t = int'(by);
    return (l <= x1) && (l + PLAYER_W - 1 >= x0) && (t <= y1) && (t + PLAYER_H - 1 >= y0);
  endfunction

  // Candidate target one tile away in the key direction
  always_comb begin
    w_key_valid = 1'b1;
    w_dir       = 2'b00;
    w_tx        = $signed({2'b00, r_x});
    w_ty        = $signed({2'b00, r_y});
    case (keycode)
      8'h1A:   begin w_dir = 2'b01; w_ty = w_ty - c_TILE; end
      8'h16:   begin w_dir = 2'b00; w_ty = w_ty + c_TILE; end
      8'h04:   begin w_dir = 2'b10; w_tx = w_tx - c_TILE; end
      8'h07:   begin w_dir = 2'b11; w_tx = w_tx + c_TILE; end
      default: w_key_valid = 1'b0;
    endcase
  end

  assign w_oob = (w_tx < 12'sd0) || (w_ty < 12'sd0) ||
                 (w_tx + c_PW > 12'sd640) || (w_ty + c_PH > 12'sd480);

`ifdef PLAYER_NOCLIP_EN
  assign w_hit = 1'b0;
`else
  assign w_hit = f_hit(w_tx, w_ty,   0, 399,  60,  78) ||
                 f_hit(w_tx, w_ty, 500, 639, 200, 218) ||
                 f_hit(w_tx, w_ty,   0, 299, 300, 318) ||
                 f_hit(w_tx, w_ty, 440, 458, 340, 398) ||
                 f_hit(w_tx, w_ty, 440, 639, 399, 418);
`endif

  assign w_blocked = w_oob || w_hit;

  always_comb begin
    w_sx = r_x;
    w_sy = r_y;
    if (r_x < r_tx)      w_sx = r_x + c_STEP;
    else if (r_x > r_tx) w_sx = r_x - c_STEP;
    if (r_y < r_ty)      w_sy = r_y + c_STEP;
    else if (r_y > r_ty) w_sy = r_y - c_STEP;
  end

  assign w_grass = (w_sx <= 10'd299) && (w_sy >= 10'd320) && (w_sy <= 10'd479);

  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_tx_nxt     = r_tx;
    w_ty_nxt     = r_ty;
    w_facing_nxt = r_facing;
    w_anim_nxt   = r_anim;
    w_acnt_nxt   = r_acnt;
    w_enc_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_tick) begin
          if (w_key_valid) begin
            w_facing_nxt = w_dir;
            if (!w_blocked) begin
              w_tx_nxt    = w_tx[9:0];
              w_ty_nxt    = w_ty[9:0];
              w_acnt_nxt  = 2'd0;
              w_state_nxt = ST_WALK;
            end
          end else begin
            w_anim_nxt = 1'b0;
          end
        end
      end
      ST_WALK: begin
        if (r_tick) begin
          w_x_nxt    = w_sx;
          w_y_nxt    = w_sy;
          w_acnt_nxt = r_acnt + 2'd1;
          if (r_acnt == 2'd3) w_anim_nxt = ~r_anim;
          if (w_sx == r_tx && w_sy == r_ty) begin
            if (w_grass && ({1'b0, r_lfsr[3:0]} < c_ENC)) begin
              w_enc_nxt   = 1'b1;
              w_state_nxt = ST_ENC;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      ST_ENC: begin
        // battle_done outranks any coincident frame tick
        if (battle_done) begin
          w_anim_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_x      <= c_START_X;
      r_y      <= c_START_Y;
      r_tx     <= c_START_X;
      r_ty     <= c_START_Y;
      r_facing <= 2'b00;
      r_anim   <= 1'b0;
      r_acnt   <= 2'd0;
      r_enc    <= 1'b0;
      r_fs1    <= 1'b0;
      r_fs2    <= 1'b0;
      r_fs3    <= 1'b0;
      r_tick   <= 1'b0;
      r_lfsr   <= c_SEED;
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_tx     <= w_tx_nxt;
      r_ty     <= w_ty_nxt;
      r_facing <= w_facing_nxt;
      r_anim   <= w_anim_nxt;
      r_acnt   <= w_acnt_nxt;
      r_enc    <= w_enc_nxt;
      r_fs1    <= frame_clk;
      r_fs2    <= r_fs1;
      r_fs3    <= r_fs2;
      r_tick   <= r_fs2 & ~r_fs3;
      r_lfsr   <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign PlayerX    = r_x;
  assign PlayerY    = r_y;
  assign facing     = r_facing;
  assign anim_frame = r_anim;
  assign encounter  = r_enc;
  assign in_battle  = (r_state == ST_ENC);

endmodule
`default_nettype wire
